// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - field indices and set-mode state enum shared with the time counter
package time_pkg;

  localparam int NUM_FIELDS = 6;
  localparam int FLD_SEC    = 0;
  localparam int FLD_MIN    = 1;
  localparam int FLD_HOUR   = 2;
  localparam int FLD_DAY    = 3;
  localparam int FLD_MONTH  = 4;
  localparam int FLD_YEAR   = 5;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_YEAR,
    ST_SET_MONTH,
    ST_SET_DAY,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC
  } set_state_e;

  function automatic logic [NUM_FIELDS-1:0] field_onehot(input set_state_e s);
    logic [NUM_FIELDS-1:0] one;
    one = NUM_FIELDS'(1);
    case (s)
      ST_SET_YEAR:  return one << FLD_YEAR;
      ST_SET_MONTH: return one << FLD_MONTH;
      ST_SET_DAY:   return one << FLD_DAY;
      ST_SET_HOUR:  return one << FLD_HOUR;
      ST_SET_MIN:   return one << FLD_MIN;
      ST_SET_SEC:   return one << FLD_SEC;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - raw buttons in, run/adjust/up/down controls out
interface time_set_ctrl_if;
  import time_pkg::*;

  logic                  btn_mode;
  logic                  btn_up;
  logic                  btn_down;
  logic                  run;
  logic [NUM_FIELDS-1:0] adjust;
  logic [NUM_FIELDS-1:0] up;
  logic [NUM_FIELDS-1:0] down;

  modport master (output btn_mode, btn_up, btn_down, input run, adjust, up, down);
  modport slave  (input btn_mode, btn_up, btn_down, output run, adjust, up, down);
endinterface

// File: rtl/time_set_ctrl_debounce.sv
// rtl/time_set_ctrl_debounce.sv - btn_debounce: synchroniser, debounce counter, rising-edge event
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic evt
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync;
  logic          level_q;
  logic [CW-1:0] cnt;

  // the count never passes DEBOUNCE_CYC-1: the flip happens on the edge it would reach DEBOUNCE_CYC
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      evt     <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      evt     <= level & ~level_q;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - set-mode FSM for the clock/calendar; TIME_SET_AUTOREPEAT_EN adds up/down auto-repeat
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT_CYC  = 30000
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic mode_lvl, up_lvl, dn_lvl;
  logic mode_evt, up_evt, dn_evt;
  logic any_evt, timeout, strobe_ok, rep_up, rep_dn;
  logic [TW-1:0] idle_cnt;
  set_state_e state, next_state;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk(clk), .rst(rst), .btn(bus.btn_mode), .level(mode_lvl), .evt(mode_evt));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
    .clk(clk), .rst(rst), .btn(bus.btn_up), .level(up_lvl), .evt(up_evt));
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_down (
    .clk(clk), .rst(rst), .btn(bus.btn_down), .level(dn_lvl), .evt(dn_evt));

  assign any_evt = mode_evt | up_evt | dn_evt;
  // an event in the same cycle counts as activity, so it wins over the timeout
  assign timeout = (TIMEOUT_CYC != 0) && (state != ST_RUN) && !any_evt &&
                   (idle_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_RUN || any_evt) idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYC)) idle_cnt <= idle_cnt + 1'b1;
  end

  always_comb begin
    next_state = state;
    bus.up     = '0;
    bus.down   = '0;
    if (mode_evt) next_state = (state == ST_SET_SEC) ? ST_RUN : set_state_e'(state + 3'd1);
    else if (timeout) next_state = ST_RUN;
    strobe_ok = (state != ST_RUN) && (next_state == state);
    if (strobe_ok) begin
      if ((up_evt && !dn_evt) || rep_up) bus.up   = field_onehot(state);
      if ((dn_evt && !up_evt) || rep_dn) bus.down = field_onehot(state);
    end
  end

  assign bus.run    = (state == ST_RUN);
  assign bus.adjust = field_onehot(state);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_arm, rep_first, rep_hold, rep_hit;
  logic          unused_lvl;

  assign unused_lvl = mode_lvl;
  // repeat only follows a press that produced a real strobe; a button held through reset never arms it
  assign rep_hold = rep_arm && (up_lvl ^ dn_lvl) && !any_evt;
  assign rep_hit  = rep_hold &&
                    (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
  assign rep_up   = rep_hit && up_lvl;
  assign rep_dn   = rep_hit && dn_lvl;

  always_ff @(posedge clk) begin
    if (rst || state == ST_RUN || mode_evt || !(up_lvl ^ dn_lvl)) begin
      rep_arm   <= 1'b0;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (up_evt || dn_evt) begin
      rep_arm   <= strobe_ok && (up_evt ^ dn_evt);
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_arm) begin
      if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_rep = REPEAT_DELAY + REPEAT_RATE;
  logic unused_lvl;

  assign unused_lvl = ^{mode_lvl, up_lvl, dn_lvl};
  assign rep_up     = 1'b0;
  assign rep_dn     = 1'b0;
`endif
endmodule
